csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR file and trap controller for the RV32I core, sitting directly downstream of the E/M pipeline registers. It consumes the memory-stage instruction word, CSR read/write enables and system-instruction class, and returns `csr_rdataM_o`, which is registered into writeback. It also owns the 64-bit cycle and retired-instruction counters, and raises PC redirects for ECALL, EBREAK, MRET and illegal CSR accesses.

## Interface
Parameters:
- `MHARTID`, 32'h0, value returned by mhartid
- `MTVEC_RESET`, 32'h0000_0000, mtvec value after reset

Ports:
- `clk_i`  in  1  sole clock
- `rst_i`  in  1  reset; **one clock; reset is synchronous and active-high**
- `instrM_i`  in  32  M-stage instruction word
- `csr_readM_i`  in  1  M-stage instruction reads a CSR
- `csr_writeM_i`  in  1  M-stage instruction writes a CSR
- `sys_instrM_i`  in  exc_t  M-stage system-instruction class
- `rs1_valueM_i`  in  32  rs1 operand for register-form CSR ops
- `pcM_i`  in  32  M-stage PC
- `stallM_i`  in  1  M stage held; suppresses all state updates
- `instr_retiredW_i`  in  1  one instruction retired this cycle
- `csr_rdataM_o`  out  32  old CSR value, combinational
- `trap_o`  out  1  take trap this cycle
- `mret_o`  out  1  MRET executing this cycle
- `redirect_pc_o`  out  32  target PC when `trap_o` or `mret_o` is high

## Operation
- Address = `instrM_i[31:20]`; op = `funct3 = instrM_i[14:12]`.
- Operand source:
  - funct3 001/010/011 (RW/RS/RC) use `rs1_valueM_i`.
  - funct3 101/110/111 use `zimm = {27'b0, instrM_i[19:15]}`.
- New value by op: RW gives operand; RS gives old|operand; RC gives old&~operand.
- Decode clears `csr_writeM_i` for RS/RC when the source is zero. This block obeys `csr_writeM_i` only.
- Implemented registers:
  - mstatus 0x300: only MIE[3], MPIE[7] writable; MPP[12:11] reads as 2'b11.
  - misa 0x301: read-only, 0x4000_0100.
  - mtvec 0x305: bits[1:0] read as 0.
  - mscratch 0x340, read/write.
  - mepc 0x341: bits[1:0] read as 0.
  - mcause 0x342, read/write.
  - mtval 0x343, read/write.
  - mcycle/mcycleh 0xB00/0xB80, read/write.
  - minstret/minstreth 0xB02/0xB82, read/write.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only shadows.
  - mhartid 0xF14, read-only.
- Illegal CSR access: either of the following causes a trap with mcause=2 and mtval=`instrM_i`, and no CSR is written.
  - An access (read or write) to an unimplemented address.
  - `csr_writeM_i` with `addr[11:10]==2'b11`.
- `csr_rdataM_o` returns 0 for an illegal access.
- ECALL: mepc←`pcM_i`, mcause←11, mtval←0, MPIE←MIE, MIE←0. `trap_o`=1, redirect = mtvec.
- EBREAK: same as ECALL, except mcause←3 and mtval←`pcM_i`.
- MRET: MIE←MPIE, MPIE←1. `mret_o`=1, redirect = mepc.
- Priority: illegal CSR > ECALL/EBREAK > MRET > ordinary CSR write.
- Counters:
  - mcycle increments every unstalled or stalled cycle when `rst_i`=0.
  - minstret increments when `instr_retiredW_i` is high.
  - Both are 64-bit and wrap from 2^64−1 to 0.
  - A software write to either half replaces that half that cycle, with no increment in the same cycle.

## Timing
- Reads are combinational within M, with zero latency. The datapath registers the result into W.
- Every CSR write and trap side-effect commits on the rising edge ending the M cycle, and only when `stallM_i`=0.
- `trap_o`, `mret_o` and `redirect_pc_o` are combinational from M inputs.
  - They are gated low while `stallM_i` or `rst_i` is high.
  - The hazard unit flushes F–M on the same cycle.
- Read-then-write on the same CSR: `csr_rdataM_o` returns the pre-write value.
- Reset values:
  - mstatus=0x0000_1800, mtvec=`MTVEC_RESET`.
  - mscratch, mepc, mcause, mtval, mcycle and minstret all 0.
  - `trap_o`, `mret_o` and `redirect_pc_o` are 0 while `rst_i` is high.
- Reset asserted mid-trap: reset wins; no mepc or mcause update occurs.
- Counter write while stalled: ignored. The counter still increments.

## Structure
- `riscv_pkg` gains:
  - CSR address constants `CSR_MSTATUS` … `CSR_MHARTID`.
  - mcause codes `CAUSE_ILLEGAL_INSTR`=2, `CAUSE_BREAKPOINT`=3, `CAUSE_ECALL_M`=11.
  - `csr_op_e` for funct3.
  - `exc_t` members `NO_SYS`, `ECALL`, `EBREAK`, `MRET`.
- Sub-module `csr_counter64`, instantiated twice (mcycle, minstret). It takes `inc_i`, `wr_lo_i`, `wr_hi_i` and `wdata_i`, and outputs `count_o[63:0]`.

## Test plan
- Reset → read mstatus=0x0000_1800, mtvec=`MTVEC_RESET`, mcycle increments from 0 each cycle.
- CSRRW mscratch with rs1=0xDEAD_BEEF, then CSRRS with rs1=0x0000_00F0 → second read returns 0xDEAD_BEEF, final value 0xDEAD_BEFF. CSRRCI zimm=0x0F → 0xDEAD_BEF0.
- MIE=1, ECALL at pc=0x100, mtvec=0x200:
  - `trap_o`=1 and redirect=0x200.
  - mepc=0x100, mcause=11, MIE=0, MPIE=1.
  - A following MRET → redirect=0x100, MIE=1.
- Write to cycle (0xC00) or read of 0x7C0 → `trap_o`=1, mcause=2, mtval=instruction word, target CSR unchanged.
- Write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF → wrap to 0; minstret write coinciding with `instr_retiredW_i` holds the written value.
- `stallM_i`=1 during CSRRW mepc and during ECALL → no state change, `trap_o`=0; release the stall → commit on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I machine-mode CSR constants and types
// Purpose: CSR addresses, mcause codes, CSR op and system-instruction enums,
//          and the read-modify-write helper used by the CSR file.
// Ports:   none (package).
package riscv_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT    = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    NO_SYS = 2'd0,
    ECALL  = 2'd1,
    EBREAK = 2'd2,
    MRET   = 2'd3
  } exc_t;

  // Non-CSR funct3 encodings leave the register unchanged.
  function automatic logic [31:0] csr_new_value(input logic [2:0] funct3,
                                                input logic [31:0] old_value,
                                                input logic [31:0] operand);
    case (funct3)
      CSR_OP_RW, CSR_OP_RWI: csr_new_value = operand;
      CSR_OP_RS, CSR_OP_RSI: csr_new_value = old_value | operand;
      CSR_OP_RC, CSR_OP_RCI: csr_new_value = old_value & ~operand;
      default:               csr_new_value = old_value;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half software writes
// Purpose: backs mcycle and minstret; a half write replaces that half and
//          suppresses the increment for that cycle.
// Ports:   clk_i, rst_i (sync, active-high), inc_i, wr_lo_i, wr_hi_i,
//          wdata_i[31:0], count_o[63:0].
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= 64'd0;
    end else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_o[31:0]  <= wdata_i;
      if (wr_hi_i) count_o[63:32] <= wdata_i;
    end else if (inc_i) begin
      count_o <= count_o + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file and trap controller for the RV32I core
// Purpose: combinational CSR read in M, CSR writes and trap/MRET side-effects
//          committed at the end of an unstalled M cycle, 64-bit counters.
// Ports:   clk_i, rst_i (sync, active-high); instrM_i, csr_readM_i,
//          csr_writeM_i, sys_instrM_i, rs1_valueM_i, pcM_i, stallM_i,
//          instr_retiredW_i in; csr_rdataM_o, trap_o, mret_o, redirect_pc_o out.
module csr_file
  import riscv_pkg::*;
#(
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instrM_i,
  input  logic        csr_readM_i,
  input  logic        csr_writeM_i,
  input  exc_t        sys_instrM_i,
  input  logic [31:0] rs1_valueM_i,
  input  logic [31:0] pcM_i,
  input  logic        stallM_i,
  input  logic        instr_retiredW_i,
  output logic [31:0] csr_rdataM_o,
  output logic        trap_o,
  output logic        mret_o,
  output logic [31:0] redirect_pc_o
);

  logic [11:0] addr;
  logic [2:0]  funct3;
  logic [31:0] operand;
  logic [31:0] old_value;
  logic [31:0] new_value;
  logic        implemented;
  logic        illegal;
  logic        is_exc;
  logic        take_trap;
  logic        is_mret;
  logic        csr_commit;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [31:0] mstatus_rd, mtvec_rd, mepc_rd;
  logic [63:0] mcycle, minstret;

  assign addr    = instrM_i[31:20];
  assign funct3  = instrM_i[14:12];
  assign operand = funct3[2] ? {27'b0, instrM_i[19:15]} : rs1_valueM_i;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  assign mtvec_rd   = {mtvec[31:2], 2'b00};
  assign mepc_rd    = {mepc[31:2], 2'b00};

  always_comb begin
    implemented = 1'b1;
    old_value   = 32'h0;
    case (addr)
      CSR_MSTATUS:                old_value = mstatus_rd;
      CSR_MISA:                   old_value = MISA_VALUE;
      CSR_MTVEC:                  old_value = mtvec_rd;
      CSR_MSCRATCH:               old_value = mscratch;
      CSR_MEPC:                   old_value = mepc_rd;
      CSR_MCAUSE:                 old_value = mcause;
      CSR_MTVAL:                  old_value = mtval;
      CSR_MCYCLE,   CSR_CYCLE:    old_value = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   old_value = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  old_value = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_value = minstret[63:32];
      CSR_MHARTID:                old_value = MHARTID;
      default:                    implemented = 1'b0;
    endcase
  end

  // addr[11:10]==11 marks the read-only CSR space.
  assign illegal = (csr_readM_i || csr_writeM_i) &&
                   (!implemented || (csr_writeM_i && addr[11:10] == 2'b11));

  assign new_value    = csr_new_value(funct3, old_value, operand);
  assign csr_rdataM_o = illegal ? 32'h0 : old_value;

  assign is_exc    = (sys_instrM_i == ECALL) || (sys_instrM_i == EBREAK);
  assign take_trap = illegal || is_exc;
  assign is_mret   = !take_trap && (sys_instrM_i == MRET);

  always_comb begin
    trap_cause = CAUSE_ECALL_M;
    trap_tval  = 32'h0;
    if (illegal) begin
      trap_cause = CAUSE_ILLEGAL_INSTR;
      trap_tval  = instrM_i;
    end else if (sys_instrM_i == EBREAK) begin
      trap_cause = CAUSE_BREAKPOINT;
      trap_tval  = pcM_i;
    end
  end

  assign trap_o        = take_trap && !stallM_i && !rst_i;
  assign mret_o        = is_mret && !stallM_i && !rst_i;
  assign redirect_pc_o = trap_o ? mtvec_rd : (mret_o ? mepc_rd : 32'h0);

  assign csr_commit = csr_writeM_i && !take_trap && !is_mret && !stallM_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= 32'h0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
    end else if (!stallM_i) begin
      if (take_trap) begin
        mepc   <= pcM_i;
        mcause <= trap_cause;
        mtval  <= trap_tval;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (is_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (csr_commit) begin
        case (addr)
          CSR_MSTATUS: begin
            mie  <= new_value[3];
            mpie <= new_value[7];
          end
          CSR_MTVEC:    mtvec    <= new_value;
          CSR_MSCRATCH: mscratch <= new_value;
          CSR_MEPC:     mepc     <= new_value;
          CSR_MCAUSE:   mcause   <= new_value;
          CSR_MTVAL:    mtval    <= new_value;
          default:      ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_commit && addr == CSR_MCYCLE),
    .wr_hi_i (csr_commit && addr == CSR_MCYCLEH),
    .wdata_i (new_value),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instr_retiredW_i),
    .wr_lo_i (csr_commit && addr == CSR_MINSTRET),
    .wr_hi_i (csr_commit && addr == CSR_MINSTRETH),
    .wdata_i (new_value),
    .count_o (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        csr_read;
  logic        csr_write;
  exc_t        sys_instr;
  logic [31:0] rs1_value;
  logic [31:0] pc;
  logic        stall;
  logic        retired;
  logic [31:0] rdata;
  logic        trap;
  logic        mret;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  csr_file #(.MHARTID(32'h0), .MTVEC_RESET(32'h0)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instrM_i         (instr),
    .csr_readM_i      (csr_read),
    .csr_writeM_i     (csr_write),
    .sys_instrM_i     (sys_instr),
    .rs1_valueM_i     (rs1_value),
    .pcM_i            (pc),
    .stallM_i         (stall),
    .instr_retiredW_i (retired),
    .csr_rdataM_o     (rdata),
    .trap_o           (trap),
    .mret_o           (mret),
    .redirect_pc_o    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] csr_instr(input logic [11:0] a, input logic [4:0] src,
                                            input logic [2:0] f3);
    csr_instr = {a, src, f3, 5'd1, 7'b1110011};
  endfunction

  task automatic idle();
    instr     = 32'h0000_0013;
    csr_read  = 1'b0;
    csr_write = 1'b0;
    sys_instr = NO_SYS;
    rs1_value = 32'h0;
    pc        = 32'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Combinational CSRRS-x0 read; does not advance time past the cycle.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    instr    = csr_instr(a, 5'd0, 3'b010);
    csr_read = 1'b1;
    #1;
    check(tag, rdata, exp);
    idle();
  endtask

  task automatic drive_op(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] src,
                          input logic [31:0] rs1v);
    instr     = csr_instr(a, src, f3);
    csr_read  = 1'b1;
    csr_write = 1'b1;
    rs1_value = rs1v;
    #1;
  endtask

  // CSR op checking the returned old value, committed on the next edge.
  task automatic op(input string tag, input logic [11:0] a, input logic [2:0] f3,
                    input logic [4:0] src, input logic [31:0] rs1v, input logic [31:0] exp_old);
    drive_op(a, f3, src, rs1v);
    check(tag, rdata, exp_old);
    next();
    idle();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] rs1v);
    drive_op(a, 3'b001, 5'd1, rs1v);
    next();
    idle();
  endtask

  initial begin
    logic [31:0] iw;
    idle();
    rst     = 1'b1;
    stall   = 1'b0;
    retired = 1'b0;
    next();
    // ECALL presented during reset must have no effect.
    sys_instr = ECALL;
    pc        = 32'h0000_0500;
    #1;
    check("rst_trap", {31'b0, trap}, 32'h0);
    check("rst_redirect", redirect_pc, 32'h0);
    next();
    idle();
    rst = 1'b0;

    rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd("rst_mtvec", CSR_MTVEC, 32'h0);
    rd("rst_mepc", CSR_MEPC, 32'h0);
    rd("rst_mcause", CSR_MCAUSE, 32'h0);
    rd("mcycle_0", CSR_MCYCLE, 32'd0);
    next();
    rd("mcycle_1", CSR_MCYCLE, 32'd1);
    next();
    rd("mcycle_2", CSR_MCYCLE, 32'd2);
    rd("misa", CSR_MISA, 32'h4000_0100);
    rd("mhartid", CSR_MHARTID, 32'h0);

    op("csrrw_mscratch", CSR_MSCRATCH, 3'b001, 5'd2, 32'hDEAD_BEEF, 32'h0);
    op("csrrs_mscratch", CSR_MSCRATCH, 3'b010, 5'd2, 32'h0000_00F0, 32'hDEAD_BEEF);
    op("csrrci_mscratch", CSR_MSCRATCH, 3'b111, 5'h0F, 32'h0, 32'hDEAD_BEFF);
    rd("mscratch_final", CSR_MSCRATCH, 32'hDEAD_BEF0);

    op("csrrw_mtvec", CSR_MTVEC, 3'b001, 5'd2, 32'h0000_0203, 32'h0);
    rd("mtvec_low_bits", CSR_MTVEC, 32'h0000_0200);
    op("csrrsi_mstatus", CSR_MSTATUS, 3'b110, 5'd8, 32'h0, 32'h0000_1800);
    rd("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);

    sys_instr = ECALL;
    pc        = 32'h0000_0100;
    #1;
    check("ecall_trap", {31'b0, trap}, 32'h1);
    check("ecall_redirect", redirect_pc, 32'h0000_0200);
    check("ecall_mret", {31'b0, mret}, 32'h0);
    next();
    idle();
    rd("ecall_mepc", CSR_MEPC, 32'h0000_0100);
    rd("ecall_mcause", CSR_MCAUSE, 32'd11);
    rd("ecall_mtval", CSR_MTVAL, 32'h0);
    rd("ecall_mstatus", CSR_MSTATUS, 32'h0000_1880);

    sys_instr = MRET;
    #1;
    check("mret_o", {31'b0, mret}, 32'h1);
    check("mret_redirect", redirect_pc, 32'h0000_0100);
    check("mret_trap", {31'b0, trap}, 32'h0);
    next();
    idle();
    rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    sys_instr = EBREAK;
    pc        = 32'h0000_0144;
    #1;
    check("ebreak_trap", {31'b0, trap}, 32'h1);
    next();
    idle();
    rd("ebreak_mcause", CSR_MCAUSE, 32'd3);
    rd("ebreak_mtval", CSR_MTVAL, 32'h0000_0144);
    rd("ebreak_mstatus", CSR_MSTATUS, 32'h0000_1880);

    iw = csr_instr(CSR_CYCLEH, 5'd2, 3'b001);
    drive_op(CSR_CYCLEH, 3'b001, 5'd2, 32'h0000_0055);
    check("illegal_wr_trap", {31'b0, trap}, 32'h1);
    check("illegal_wr_rdata", rdata, 32'h0);
    check("illegal_wr_redirect", redirect_pc, 32'h0000_0200);
    next();
    idle();
    rd("illegal_wr_mcause", CSR_MCAUSE, 32'd2);
    rd("illegal_wr_mtval", CSR_MTVAL, iw);
    rd("cycleh_unchanged", CSR_CYCLEH, 32'h0);

    iw       = csr_instr(12'h7C0, 5'd0, 3'b010);
    instr    = iw;
    csr_read = 1'b1;
    #1;
    check("illegal_rd_trap", {31'b0, trap}, 32'h1);
    check("illegal_rd_rdata", rdata, 32'h0);
    next();
    idle();
    rd("illegal_rd_mtval", CSR_MTVAL, iw);

    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd("mcycle_max_lo", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcycle_max_hi", CSR_MCYCLEH, 32'hFFFF_FFFF);
    next();
    rd("mcycle_wrap_lo", CSR_MCYCLE, 32'h0);
    rd("mcycle_wrap_hi", CSR_MCYCLEH, 32'h0);

    retired = 1'b1;
    wr(CSR_MINSTRET, 32'h0000_1234);
    retired = 1'b0;
    rd("minstret_wr_wins", CSR_MINSTRET, 32'h0000_1234);
    retired = 1'b1;
    next();
    retired = 1'b0;
    rd("minstret_inc", CSR_MINSTRET, 32'h0000_1235);
    rd("instret_shadow", CSR_INSTRET, 32'h0000_1235);

    wr(CSR_MEPC, 32'h0000_0300);
    stall = 1'b1;
    drive_op(CSR_MEPC, 3'b001, 5'd2, 32'h0000_0AB0);
    check("stall_wr_trap", {31'b0, trap}, 32'h0);
    next();
    rd("stall_mepc_held", CSR_MEPC, 32'h0000_0300);
    stall = 1'b0;
    wr(CSR_MEPC, 32'h0000_0AB0);
    rd("unstall_mepc", CSR_MEPC, 32'h0000_0AB0);

    stall     = 1'b1;
    sys_instr = ECALL;
    pc        = 32'h0000_0400;
    #1;
    check("stall_ecall_trap", {31'b0, trap}, 32'h0);
    check("stall_ecall_redirect", redirect_pc, 32'h0);
    next();
    idle();
    rd("stall_ecall_mepc", CSR_MEPC, 32'h0000_0AB0);
    rd("stall_ecall_mcause", CSR_MCAUSE, 32'd2);
    stall     = 1'b0;
    sys_instr = ECALL;
    pc        = 32'h0000_0400;
    #1;
    check("unstall_ecall_trap", {31'b0, trap}, 32'h1);
    next();
    idle();
    rd("unstall_ecall_mepc", CSR_MEPC, 32'h0000_0400);
    rd("unstall_ecall_mcause", CSR_MCAUSE, 32'd11);

    stall   = 1'b1;
    retired = 1'b1;
    wr(CSR_MINSTRET, 32'h0000_0077);
    retired = 1'b0;
    stall   = 1'b0;
    rd("stall_minstret_inc", CSR_MINSTRET, 32'h0000_1236);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
